// File: rtl/button_debounce_pkg.sv
// button_debounce_pkg: shared FSM state type and default timing parameters
package button_debounce_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_PEND,
        HELD,
        LONG,
        RELEASE_PEND
    } state_t;

    // 20 ms debounce and 1 s long-press at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int LONG_CYCLES_DEF     = 50_000_000;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous pad inputs, clears to 0 on reset
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // first flop may go metastable; second gives it a full cycle to resolve
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronise, debounce and classify press/release/long-press of a raw button
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int CNT_W           = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             btn_i,
    output logic             btn_level_o,
    output logic             press_o,
    output logic             release_o,
    output logic             long_o,
    output logic [CNT_W-1:0] press_cnt_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int HD_W = $clog2(LONG_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(LONG_CYCLES - 1);

    logic            btn_s;
    state_t          state;
    logic [DB_W-1:0] db_cnt;
    logic [HD_W-1:0] hold_cnt;
    logic            was_long;

    sync_2ff #(.W(1)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d      (btn_i),
        .q      (btn_s)
    );

    // debounce/classification FSM; pulses default low so each lasts exactly one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            was_long    <= 1'b0;
            btn_level_o <= 1'b0;
            press_o     <= 1'b0;
            release_o   <= 1'b0;
            long_o      <= 1'b0;
            press_cnt_o <= '0;
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state  <= PRESS_PEND;
                        db_cnt <= DB_W'(1);
                    end
                end
                PRESS_PEND: begin
                    if (!btn_s) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= HELD;
                        db_cnt      <= '0;
                        hold_cnt    <= '0;
                        btn_level_o <= 1'b1;
                        press_o     <= 1'b1;
                        press_cnt_o <= press_cnt_o + 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state    <= RELEASE_PEND;
                        db_cnt   <= DB_W'(1);
                        was_long <= 1'b0;
                    end else if (hold_cnt == HD_LAST) begin
                        state  <= LONG;
                        long_o <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (!btn_s) begin
                        state    <= RELEASE_PEND;
                        db_cnt   <= DB_W'(1);
                        was_long <= 1'b1;
                    end
                end
                RELEASE_PEND: begin
                    // a bounce back to pressed resumes the hold where it paused
                    if (btn_s) begin
                        state  <= was_long ? LONG : HELD;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= IDLE;
                        db_cnt      <= '0;
                        btn_level_o <= 1'b0;
                        release_o   <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed self-checking bench for button_debounce (D=4, L=20, CNT_W=2)
module tb_button_debounce;
    import button_debounce_pkg::*;

    logic       clk_i;
    logic       rst_ni;
    logic       btn_i;
    logic       btn_level_o;
    logic       press_o;
    logic       release_o;
    logic       long_o;
    logic [1:0] press_cnt_o;

    int errors = 0;
    int checks = 0;

    button_debounce #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .CNT_W           (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .btn_i       (btn_i),
        .btn_level_o (btn_level_o),
        .press_o     (press_o),
        .release_o   (release_o),
        .long_o      (long_o),
        .press_cnt_o (press_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_level"}, 32'(btn_level_o), 0);
        chk({tag, "_press"}, 32'(press_o), 0);
        chk({tag, "_release"}, 32'(release_o), 0);
        chk({tag, "_long"}, 32'(long_o), 0);
        chk({tag, "_cnt"}, 32'(press_cnt_o), 0);
    endtask

    // advance n edges, checking each pulse fires only on its expected edge (0 = never)
    task automatic window(input string tag, input int n, input int pe, input int re, input int le);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("%s_press@%0d", tag, k), 32'(press_o), 32'(k == pe));
            chk($sformatf("%s_release@%0d", tag, k), 32'(release_o), 32'(k == re));
            chk($sformatf("%s_long@%0d", tag, k), 32'(long_o), 32'(k == le));
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        btn_i  = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        all_zero("reset_hold");
        rst_ni = 1'b1;

        window("first_press", 8, 6, 0, 0);
        chk("first_level", 32'(btn_level_o), 1);
        chk("first_cnt", 32'(press_cnt_o), 1);
        btn_i = 1'b0;
        window("first_release", 8, 0, 6, 0);
        chk("first_rel_level", 32'(btn_level_o), 0);

        btn_i = 1'b1;
        window("bounce_hi", 3, 0, 0, 0);
        btn_i = 1'b0;
        window("bounce_lo", 8, 0, 0, 0);
        chk("bounce_level", 32'(btn_level_o), 0);
        chk("bounce_cnt", 32'(press_cnt_o), 1);
        chk("bounce_state", 32'(dut.state), 32'(IDLE));

        btn_i = 1'b1;
        window("clean_press", 10, 6, 0, 0);
        chk("clean_level", 32'(btn_level_o), 1);
        chk("clean_cnt", 32'(press_cnt_o), 2);
        btn_i = 1'b0;
        window("clean_release", 10, 0, 6, 0);
        chk("clean_rel_level", 32'(btn_level_o), 0);

        btn_i = 1'b1;
        window("long_press", 40, 6, 0, 26);
        chk("long_level", 32'(btn_level_o), 1);
        chk("long_cnt", 32'(press_cnt_o), 3);
        btn_i = 1'b0;
        window("rel_bounce_lo", 2, 0, 0, 0);
        btn_i = 1'b1;
        window("rel_bounce_hi", 10, 0, 0, 0);
        chk("rel_bounce_level", 32'(btn_level_o), 1);
        chk("rel_bounce_state", 32'(dut.state), 32'(LONG));
        btn_i = 1'b0;
        window("long_release", 10, 0, 6, 0);
        chk("long_rel_level", 32'(btn_level_o), 0);
        chk("long_rel_cnt", 32'(press_cnt_o), 3);

        rst_ni = 1'b0;
        #2;
        all_zero("async_reset_idle");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 5; i++) begin
            btn_i = 1'b1;
            window($sformatf("wrap%0d_press", i), 8, 6, 0, 0);
            chk($sformatf("wrap%0d_cnt", i), 32'(press_cnt_o), 32'((i + 1) % 4));
            btn_i = 1'b0;
            window($sformatf("wrap%0d_release", i), 8, 0, 6, 0);
        end

        btn_i = 1'b1;
        window("midpend", 4, 0, 0, 0);
        chk("midpend_state", 32'(dut.state), 32'(PRESS_PEND));
        rst_ni = 1'b0;
        #2;
        all_zero("midpend_reset");
        chk("midpend_reset_state", 32'(dut.state), 32'(IDLE));
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        window("after_reset", 8, 6, 0, 0);
        chk("after_reset_cnt", 32'(press_cnt_o), 1);
        chk("after_reset_level", 32'(btn_level_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
